// File: rtl/uart_rx_if.sv
// Ready/valid byte channel between the UART receiver and its consumer.
// Field names match the transmitter's channel so the same stages attach to either.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB first, stop bit checked once at mid-bit.
// Byte delivered on a ready/valid channel; framing error and overrun are one-cycle pulses.
module uart_rx #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_rxd,
  uart_rx_if.master  io_channel,
  output logic       io_frame_err,
  output logic       io_overrun
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic [1:0]    sync_q;
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], io_rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && io_channel.ready)
      valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = FULL_M1;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (idx_q == 3'd7)
            state_d = S_STOP;
          else
            idx_d = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            // A byte completing on the handshake edge replaces the consumed one.
            if (valid_q && !io_channel.ready) begin
              ovr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign io_channel.data  = data_q;
  assign io_channel.valid = valid_q;
  assign io_frame_err     = ferr_q;
  assign io_overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=16: timing, stall/overrun, handshake race,
// framing error, glitch rejection and reset mid-frame.
module tb_uart_rx;
  localparam int DIV = 16;

  logic clk = 1'b0;
  logic reset;
  logic io_rxd;
  logic io_frame_err;
  logic io_overrun;

  uart_rx_if ch ();

  uart_rx #(.CLK_DIV(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_rxd       (io_rxd),
    .io_channel   (ch.master),
    .io_frame_err (io_frame_err),
    .io_overrun   (io_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (ch.valid && ch.ready) rx_q.push_back(ch.data);
    if (io_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (io_overrun) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; the next edge is the first to see the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int hold);
    io_rxd = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      io_rxd = b[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    io_rxd = stop_bit;
    repeat (hold) @(posedge clk);
    #1;
    io_rxd = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  int f0, o0, q0;

  initial begin
    reset    = 1'b0;
    io_rxd   = 1'b1;
    ch.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ch.valid, 0);
    chk("rst_data", ch.data, 8'h00);
    chk("rst_ferr", io_frame_err, 0);
    chk("rst_ovr", io_overrun, 0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single byte, exact sampling edge 154
    f0 = ferr_cnt; o0 = ovr_cnt; q0 = rx_q.size();
    fork
      send_frame(8'hA5, 1'b1, DIV);
      begin
        repeat (154) @(posedge clk);
        #1 chk("t1_valid_e153", ch.valid, 0);
        @(posedge clk);
        #1 chk("t1_valid_e154", ch.valid, 1);
        chk("t1_data", ch.data, 8'hA5);
        @(posedge clk);
        #1 chk("t1_valid_e155", ch.valid, 0);
      end
    join
    chk("t1_ferr", ferr_cnt - f0, 0);
    chk("t1_ovr", ovr_cnt - o0, 0);
    chk("t1_qsize", rx_q.size() - q0, 1);

    // Back-to-back with stall
    ch.ready = 1'b0;
    o0 = ovr_cnt; q0 = rx_q.size();
    send_frame(8'h00, 1'b1, DIV);
    chk("t2_valid1", ch.valid, 1);
    chk("t2_data1", ch.data, 8'h00);
    send_frame(8'hFF, 1'b1, DIV);
    chk("t2_ovr", ovr_cnt - o0, 1);
    chk("t2_data_held", ch.data, 8'h00);
    chk("t2_valid_held", ch.valid, 1);
    ch.ready = 1'b1;
    @(posedge clk);
    #1 chk("t2_valid_drop", ch.valid, 0);
    chk("t2_qsize", rx_q.size() - q0, 1);
    chk("t2_qdata", rx_q[q0], 8'h00);

    // Handshake on the completion edge of the second byte
    ch.ready = 1'b0;
    o0 = ovr_cnt; q0 = rx_q.size();
    send_frame(8'h12, 1'b1, DIV);
    fork
      send_frame(8'h55, 1'b1, DIV);
      begin
        repeat (154) @(posedge clk);
        #1 ch.ready = 1'b1;
        @(posedge clk);
        #1 ch.ready = 1'b0;
        chk("t3_valid", ch.valid, 1);
        chk("t3_data", ch.data, 8'h55);
      end
    join
    chk("t3_ovr", ovr_cnt - o0, 0);
    chk("t3_q_first", rx_q[q0], 8'h12);
    ch.ready = 1'b1;
    @(posedge clk);
    #1 chk("t3_valid_drop", ch.valid, 0);
    chk("t3_q_second", rx_q[q0 + 1], 8'h55);

    // Framing error with line held low
    f0 = ferr_cnt; q0 = rx_q.size();
    send_frame(8'h00, 1'b0, 100);
    chk("t4_ferr", ferr_cnt - f0, 1);
    chk("t4_qsize", rx_q.size() - q0, 0);
    chk("t4_valid", ch.valid, 0);
    send_frame(8'hC3, 1'b1, DIV);
    chk("t4_recover", rx_q[q0], 8'hC3);
    chk("t4_ferr_once", ferr_cnt - f0, 1);

    // Glitch rejection
    f0 = ferr_cnt; q0 = rx_q.size();
    io_rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 io_rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("t5_valid", ch.valid, 0);
    chk("t5_qsize", rx_q.size() - q0, 0);
    send_frame(8'h3C, 1'b1, DIV);
    chk("t5_data", rx_q[q0], 8'h3C);
    chk("t5_ferr", ferr_cnt - f0, 0);

    // Reset mid-frame with a pending byte
    ch.ready = 1'b0;
    send_frame(8'h99, 1'b1, DIV);
    chk("t6_pending", ch.valid, 1);
    q0 = rx_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'hE0, 1'b1, DIV);
      begin
        repeat (85) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("t6_rst_valid", ch.valid, 0);
        chk("t6_rst_data", ch.data, 8'h00);
        chk("t6_rst_ferr", io_frame_err, 0);
        chk("t6_rst_ovr", io_overrun, 0);
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
      end
    join
    ch.ready = 1'b1;
    send_frame(8'h81, 1'b1, DIV);
    repeat (2) @(posedge clk);
    #1 chk("t6_qsize", rx_q.size() - q0, 1);
    chk("t6_data", rx_q[q0], 8'h81);
    chk("t6_no_err", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: the receive counterpart of the existing 8-bit transmitter (1 start bit, 8 data bits LSB first, 2 stop bits, 434 clocks per bit at the default setting). It synchronises the asynchronous `io_rxd` pin, samples each bit at mid-period and assembles the byte. It delivers the byte on a ready/valid channel with the same field names as the transmitter's channel, so a Buffer stage or a consumer can attach directly. It sits between the board `io_rxd` pin and the top level, which currently leaves the pin unconnected.

## Interface
- `CLK_DIV`, default 434: clocks per bit period; even, ≥ 8.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset: 0 resets on the next `clk` edge.
- `io_rxd`  in  1  asynchronous serial line; idles high.
- `io_channel_data`  out  8  received byte.
- `io_channel_valid`  out  1  `io_channel_data` holds an unconsumed byte.
- `io_channel_ready`  in  1  consumer accepts the byte.
- `io_frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `io_overrun`  out  1  one-cycle pulse when a good byte is dropped because the previous byte is still valid.

## Operation
- **Synchroniser:** two flops on `io_rxd`, both reset to 1. `rx_s` is the second flop. All decisions use `rx_s` only.
- **State machine:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** if `rx_s`==0, load the down-counter with `CLK_DIV/2-1` and go to START.
  - **START:** when the counter reaches 0, sample `rx_s`.
    - 1 (glitch): go to IDLE.
    - 0: load `CLK_DIV-1`, set bit index to 0, go to DATA.
  - **DATA:** at each counter 0, shift right: `shift <= {rx_s, shift[7:1]}`. Reload `CLK_DIV-1`. After index 7, go to STOP.
  - **STOP:** at counter 0, sample `rx_s`.
    - 1, valid low: load `shift` into the output register, set valid, go to IDLE.
    - 1, valid high: keep the old data, pulse `io_overrun`, go to IDLE.
    - 0: pulse `io_frame_err`, discard the byte, go to BREAK.
  - **BREAK:** wait until `rx_s`==1, then go to IDLE. A held-low line (break) therefore yields exactly one `io_frame_err`.
- Only the first stop bit is checked. The return to IDLE at mid-stop-bit allows back-to-back frames with a tolerance of up to half a bit.
- **Output handshake:** the transfer happens on an edge where valid && ready. Valid clears on that edge unless a new byte completes on the same edge; in that case the new byte is loaded and valid stays 1 (no overrun).
- The counter is sized `$clog2(CLK_DIV)` bits. It never wraps: it is reloaded at 0.
- **Reset values:** state IDLE, counter 0, shift 0x00, `io_channel_data` 0x00, `io_channel_valid` 0, `io_frame_err` 0, `io_overrun` 0.
- **Reset mid-frame:** the frame is abandoned and any pending byte is discarded. After reset is released, the receiver waits for the next low on `rx_s`. If the line is low at that moment, it is treated as a start bit.

## Timing
- Edge 0 is the first edge that samples `io_rxd`=0. The FSM enters START at edge 2.
- The start bit is sampled at edge `2+CLK_DIV/2`.
- Data bit k is sampled at edge `2+CLK_DIV/2+(k+1)*CLK_DIV`.
- The stop bit is sampled at edge `2+CLK_DIV/2+9*CLK_DIV`. Valid, `io_frame_err` or `io_overrun` become visible after that edge.
- Default `CLK_DIV`: the stop bit is sampled at edge 4125. With `CLK_DIV`=16: edge 154.
- Valid stays high until the handshake edge. Data is stable while valid is high.
- The error pulses are registered and last exactly one cycle.

## Test plan
- **Single byte:** `CLK_DIV`=16, ready=1, frame 0xA5 with 16-cycle bits. Required: valid=1 for one cycle after edge 154, data=0xA5, no error pulses.
- **Back-to-back frames with stall:** send 0x00 then 0xFF with ready=0. Required: 0x00 held; at the second stop sample `io_overrun` pulses once; data stays 0x00. Raise ready: valid drops next edge.
- **Simultaneous handshake:** ready asserted exactly on the edge the second byte completes. Required: data=0x55 second byte, valid stays 1, no overrun.
- **Framing error:** stop bit driven 0 and line held low for 100 cycles. Required: one `io_frame_err` pulse, valid stays 0. A byte sent after the line returns high is received correctly.
- **Glitch:** `io_rxd` low for 4 cycles. Required: no output; the next 0x3C frame is received.
- **Reset mid-frame:** assert reset=0 during data bit 4, release, then send 0x81. Required: all outputs 0 during reset; only 0x81 is delivered.
